// File: rtl/sync_pkg.sv
// rtl/sync_pkg.sv - shared state encoding and default widths for the sync trigger controller
package sync_pkg;

    localparam int STATE_W   = 3;
    localparam int DEF_N_OUT = 4;
    localparam int DEF_CNT_W = 32;
    localparam int DEF_PW_W  = 8;

    // Encodings are visible on state_o, so they are fixed explicitly.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_GATE  = 3'd1,
        ST_WAIT_PHASE = 3'd2,
        ST_FIRE       = 3'd3,
        ST_WAIT_WIRE  = 3'd4,
        ST_TRIGGER    = 3'd5,
        ST_DONE       = 3'd6,
        ST_FAULT      = 3'd7
    } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - 2-FF synchroniser with rising-edge detector for one asynchronous input
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Two flops for metastability, a third remembers the last synchronised value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/sync_trigger_ctrl.sv
// rtl/sync_trigger_ctrl.sv - gated detonator fire and wire-referenced delayed triggers; SYNC_WIRE_TIMEOUT_EN adds a wire timeout
module sync_trigger_ctrl
    import sync_pkg::*;
#(
    parameter int N_OUT = DEF_N_OUT,
    parameter int CNT_W = DEF_CNT_W,
    parameter int PW_W  = DEF_PW_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic                   fast_gate_i,
    input  logic                   phase_i,
    input  logic                   wire_i,
    input  logic                   abort_i,
    input  logic [N_OUT*CNT_W-1:0] cfg_delay_i,
    input  logic [PW_W-1:0]        cfg_pulse_len_i,
    input  logic [CNT_W-1:0]       cfg_timeout_i,
    output logic                   det_o,
    output logic [N_OUT-1:0]       trig_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   fault_o,
    output logic [2:0]             state_o
);

    logic start_rise, start_lvl_unused;
    logic gate_lvl, gate_rise_unused;
    logic phase_rise, phase_lvl_unused;
    logic wire_rise, wire_lvl_unused;

    sync_edge_det u_start (.clk(clk), .rst_n(rst_n), .async_i(start_i),
                           .level_o(start_lvl_unused), .rise_o(start_rise));
    sync_edge_det u_gate  (.clk(clk), .rst_n(rst_n), .async_i(fast_gate_i),
                           .level_o(gate_lvl), .rise_o(gate_rise_unused));
    sync_edge_det u_phase (.clk(clk), .rst_n(rst_n), .async_i(phase_i),
                           .level_o(phase_lvl_unused), .rise_o(phase_rise));
    sync_edge_det u_wire  (.clk(clk), .rst_n(rst_n), .async_i(wire_i),
                           .level_o(wire_lvl_unused), .rise_o(wire_rise));

    state_e                 state_q, state_d;
    logic [N_OUT*CNT_W-1:0] delay_q, delay_d;
    logic [CNT_W-1:0]       max_q, max_d;
    logic [PW_W-1:0]        plen_q, plen_d;
    logic [PW_W-1:0]        pcnt_q, pcnt_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       cfg_max;
    logic [PW_W-1:0]        plen_eff;

`ifdef SYNC_WIRE_TIMEOUT_EN
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^cfg_timeout_i;
`endif

    // Largest configured delay, latched with the config so TRIGGER knows when the last channel fires.
    always_comb begin
        cfg_max = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (cfg_delay_i[k*CNT_W +: CNT_W] > cfg_max) cfg_max = cfg_delay_i[k*CNT_W +: CNT_W];
        end
    end

    // A zero pulse length still gives a one-cycle detonator pulse.
    assign plen_eff = (plen_q == '0) ? PW_W'(1) : plen_q;

    // Next-state logic; abort overrides everything, including a start edge in IDLE.
    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        max_d   = max_q;
        plen_d  = plen_q;
        pcnt_d  = pcnt_q;
        cnt_d   = cnt_q;
`ifdef SYNC_WIRE_TIMEOUT_EN
        tmo_d    = tmo_q;
        to_cnt_d = to_cnt_q;
`endif
        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_rise) begin
                        state_d = ST_WAIT_GATE;
                        delay_d = cfg_delay_i;
                        max_d   = cfg_max;
                        plen_d  = cfg_pulse_len_i;
`ifdef SYNC_WIRE_TIMEOUT_EN
                        tmo_d   = cfg_timeout_i;
`endif
                    end
                end
                ST_WAIT_GATE: begin
                    if (gate_lvl) state_d = ST_WAIT_PHASE;
                end
                ST_WAIT_PHASE: begin
                    // Phase edge is checked first so a coincident gate fall still fires.
                    if (phase_rise) begin
                        state_d = ST_FIRE;
                        pcnt_d  = '0;
                    end else if (!gate_lvl) begin
                        state_d = ST_WAIT_GATE;
                    end
                end
                ST_FIRE: begin
                    if (pcnt_q == plen_eff - PW_W'(1)) begin
                        state_d = ST_WAIT_WIRE;
`ifdef SYNC_WIRE_TIMEOUT_EN
                        to_cnt_d = '0;
`endif
                    end else begin
                        pcnt_d = pcnt_q + PW_W'(1);
                    end
                end
                ST_WAIT_WIRE: begin
                    if (wire_rise) begin
                        state_d = ST_TRIGGER;
                        cnt_d   = '0;
`ifdef SYNC_WIRE_TIMEOUT_EN
                    end else if ((tmo_q != '0) && (to_cnt_q == tmo_q - CNT_W'(1))) begin
                        state_d = ST_FAULT;
                    end else if (to_cnt_q != '1) begin
                        to_cnt_d = to_cnt_q + CNT_W'(1);
`endif
                    end
                end
                ST_TRIGGER: begin
                    if (cnt_q == max_q) state_d = ST_DONE;
                    else if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                end
                ST_DONE:  state_d = ST_IDLE;
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // State, latched configuration and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            delay_q <= '0;
            max_q   <= '0;
            plen_q  <= '0;
            pcnt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            delay_q <= delay_d;
            max_q   <= max_d;
            plen_q  <= plen_d;
            pcnt_q  <= pcnt_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SYNC_WIRE_TIMEOUT_EN
    // Latched timeout and the cycles spent waiting for the wire edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q    <= '0;
            to_cnt_q <= '0;
        end else begin
            tmo_q    <= tmo_d;
            to_cnt_q <= to_cnt_d;
        end
    end
    assign fault_o = (state_q == ST_FAULT);
`else
    assign fault_o = 1'b0;
`endif

    // Channel k fires on the single cycle its delay matches the post-wire counter.
    always_comb begin
        trig_o = '0;
        for (int k = 0; k < N_OUT; k++) begin
            trig_o[k] = (state_q == ST_TRIGGER) && (cnt_q == delay_q[k*CNT_W +: CNT_W]);
        end
    end

    assign det_o   = (state_q == ST_FIRE);
    assign busy_o  = (state_q != ST_IDLE);
    assign done_o  = (state_q == ST_DONE);
    assign state_o = state_q;

endmodule

// File: tb/tb_sync_trigger_ctrl.sv
// tb/tb_sync_trigger_ctrl.sv - directed table-driven bench for sync_trigger_ctrl
module tb_sync_trigger_ctrl;
    import sync_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_i = 1'b0, fast_gate_i = 1'b0, phase_i = 1'b0, wire_i = 1'b0, abort_i = 1'b0;
    logic [127:0] cfg_delay_i = '0;
    logic [7:0]   cfg_pulse_len_i = '0;
    logic [31:0]  cfg_timeout_i = '0;
    logic         det_o, busy_o, done_o, fault_o;
    logic [3:0]   trig_o;
    logic [2:0]   state_o;

    sync_trigger_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .fast_gate_i(fast_gate_i),
        .phase_i(phase_i), .wire_i(wire_i), .abort_i(abort_i),
        .cfg_delay_i(cfg_delay_i), .cfg_pulse_len_i(cfg_pulse_len_i), .cfg_timeout_i(cfg_timeout_i),
        .det_o(det_o), .trig_o(trig_o), .busy_o(busy_o), .done_o(done_o),
        .fault_o(fault_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][31:0] dly;
        logic [7:0]       pl;
        logic             extra_start;
        logic [15:0]      exp_det;
        logic [3:0][15:0] exp_trig;
        logic [15:0]      exp_done;
    } vec_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int det_first, det_cnt, done_first, done_cnt, fault_first;
    int trig_first[4];
    int trig_cnt[4];

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (det_o) begin
            if (det_cnt == 0) det_first = cyc;
            det_cnt++;
        end
        if (done_o) begin
            if (done_cnt == 0) done_first = cyc;
            done_cnt++;
        end
        if (fault_o && fault_first < 0) fault_first = cyc;
        for (int k = 0; k < 4; k++) begin
            if (trig_o[k]) begin
                if (trig_cnt[k] == 0) trig_first[k] = cyc;
                trig_cnt[k]++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        det_first = -1; det_cnt = 0; done_first = -1; done_cnt = 0; fault_first = -1;
        for (int k = 0; k < 4; k++) begin
            trig_first[k] = -1;
            trig_cnt[k] = 0;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n = 0;
        @(negedge clk);
        while (state_o !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (state_o !== s) begin
            total++;
            bad++;
            $display("FAIL %s: timed out in state %0d want %0d", name, state_o, s);
        end
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick(2);
        start_i = 1'b0;
    endtask

    // Start, open the gate, give one phase edge, and return once in WAIT_WIRE.
    task automatic arm(input logic [127:0] d, input logic [7:0] pl, input logic [31:0] tmo,
                       input string name, output int p);
        cfg_delay_i = d; cfg_pulse_len_i = pl; cfg_timeout_i = tmo;
        tick(1);
        pulse_start();
        wait_state(ST_WAIT_GATE, 10, {name, "_wg"});
        cfg_delay_i = {$urandom, $urandom, $urandom, $urandom};
        cfg_pulse_len_i = 8'hA5;
        cfg_timeout_i = 32'd7;
        tick(1);
        fast_gate_i = 1'b1;
        wait_state(ST_WAIT_PHASE, 10, {name, "_wp"});
        tick(2);
        phase_i = 1'b1;
        p = cyc;
        tick(3);
        phase_i = 1'b0;
        wait_state(ST_WAIT_WIRE, 300, {name, "_ww"});
        fast_gate_i = 1'b0;
    endtask

    task automatic pulse_wire(output int w);
        tick(2);
        wire_i = 1'b1;
        w = cyc;
        tick(3);
        wire_i = 1'b0;
    endtask

    task automatic run_rec(input vec_t r, input string name);
        int p, w, n;
        clear_mon();
        arm(r.dly, r.pl, 32'd0, name, p);
        if (r.extra_start) begin
            tick(1);
            pulse_start();
            tick(6);
            check({name, "_xstart_state"}, 32'(state_o), 32'(ST_WAIT_WIRE));
        end
        pulse_wire(w);
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        tick(5);
        check({name, "_det_start"}, det_first - p, 3);
        check({name, "_det_len"}, det_cnt, 32'(r.exp_det));
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_trig%0d_at", name, k), trig_first[k] - w, 32'(r.exp_trig[k]));
            check($sformatf("%s_trig%0d_cnt", name, k), trig_cnt[k], 1);
        end
        check({name, "_done_at"}, done_first - w, 32'(r.exp_done));
        check({name, "_done_cnt"}, done_cnt, 1);
        check({name, "_idle"}, 32'(state_o), 32'(ST_IDLE));
    endtask

    function automatic vec_t mk(input int d0, d1, d2, d3, input int pl, input bit xs,
                                input int e_det, t0, t1, t2, t3, e_done);
        vec_t v;
        v.dly = {32'(d3), 32'(d2), 32'(d1), 32'(d0)};
        v.pl = 8'(pl);
        v.extra_start = xs;
        v.exp_det = 16'(e_det);
        v.exp_trig = {16'(t3), 16'(t2), 16'(t1), 16'(t0)};
        v.exp_done = 16'(e_done);
        return v;
    endfunction

    vec_t tbl[5];

    initial begin
        int p, w, e, n;
        tbl[0] = mk(0, 10, 100, 1000, 10, 1'b0, 10, 3, 13, 103, 1003, 1004);
        tbl[1] = mk(5, 5, 5, 5, 0, 1'b1, 1, 8, 8, 8, 8, 9);
        tbl[2] = mk(7, 0, 3, 2, 1, 1'b0, 1, 10, 3, 6, 5, 11);
        tbl[3] = mk(0, 0, 0, 0, 3, 1'b0, 3, 3, 3, 3, 3, 4);
        tbl[4] = mk(1, 2, 3, 4, 255, 1'b0, 255, 4, 5, 6, 7, 8);
        clear_mon();

        #23;
        check("reset_outputs", 32'({det_o, trig_o, busy_o, done_o, fault_o, state_o}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);

        for (int i = 0; i < 5; i++) run_rec(tbl[i], $sformatf("vec%0d", i));

        // Gate closes with no phase edge, then a coincident gate fall and phase edge fires.
        clear_mon();
        cfg_delay_i = '0; cfg_pulse_len_i = 8'd2;
        tick(1);
        pulse_start();
        wait_state(ST_WAIT_GATE, 10, "gate_wg");
        tick(1);
        fast_gate_i = 1'b1;
        wait_state(ST_WAIT_PHASE, 10, "gate_wp");
        tick(2);
        fast_gate_i = 1'b0;
        wait_state(ST_WAIT_GATE, 10, "gate_back");
        tick(20);
        check("gate_closed_state", 32'(state_o), 32'(ST_WAIT_GATE));
        check("gate_closed_det", det_cnt, 0);
        fast_gate_i = 1'b1;
        wait_state(ST_WAIT_PHASE, 10, "gate_wp2");
        tick(2);
        fast_gate_i = 1'b0;
        phase_i = 1'b1;
        p = cyc;
        tick(3);
        phase_i = 1'b0;
        wait_state(ST_WAIT_WIRE, 50, "gate_ww");
        check("gate_edge_det_start", det_first - p, 3);
        check("gate_edge_det_len", det_cnt, 2);
        tick(1);
        abort_i = 1'b1;
        tick(1);
        abort_i = 1'b0;
        check("gate_abort_idle", 32'({busy_o, state_o}), 0);

        // Abort held across a start edge keeps the FSM in IDLE.
        tick(2);
        abort_i = 1'b1;
        pulse_start();
        tick(4);
        abort_i = 1'b0;
        tick(5);
        check("abort_beats_start", 32'({busy_o, state_o}), 0);

        // Abort during the detonator pulse.
        clear_mon();
        cfg_delay_i = '0; cfg_pulse_len_i = 8'd20;
        tick(1);
        pulse_start();
        wait_state(ST_WAIT_GATE, 10, "abdet_wg");
        tick(1);
        fast_gate_i = 1'b1;
        wait_state(ST_WAIT_PHASE, 10, "abdet_wp");
        tick(2);
        phase_i = 1'b1;
        tick(3);
        phase_i = 1'b0;
        tick(3);
        abort_i = 1'b1;
        tick(1);
        abort_i = 1'b0;
        fast_gate_i = 1'b0;
        @(negedge clk);
        check("abort_det_low", 32'(det_o), 0);
        check("abort_det_state", 32'(state_o), 32'(ST_IDLE));
        pulse_wire(w);
        tick(20);
        check("abort_det_len", det_cnt, 4);
        check("abort_no_trig", trig_cnt[0], 0);
        check("abort_no_done", done_cnt, 0);

        // Reset in the middle of TRIGGER, then a normal run.
        clear_mon();
        arm({32'd300, 32'd300, 32'd300, 32'd0}, 8'd1, 32'd0, "rst", p);
        pulse_wire(w);
        wait_state(ST_TRIGGER, 10, "rst_trig");
        tick(10);
        check("rst_trig0_before", trig_cnt[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_outputs", 32'({det_o, trig_o, busy_o, done_o, fault_o, state_o}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        run_rec(tbl[2], "after_rst");

        // Wire timeout with no wire edge.
        clear_mon();
        arm(128'd0, 8'd1, 32'd1000, "tmo", p);
        e = cyc;
`ifdef SYNC_WIRE_TIMEOUT_EN
        n = 0;
        while (fault_first < 0 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        check("tmo_fault_at", fault_first - e, 1000);
        check("tmo_fault_state", 32'(state_o), 32'(ST_FAULT));
        tick(10);
        check("tmo_fault_held", 32'(fault_o), 1);
`else
        tick(1100);
        check("tmo_off_fault", 32'(fault_o), 0);
        check("tmo_off_state", 32'(state_o), 32'(ST_WAIT_WIRE));
`endif
        tick(1);
        abort_i = 1'b1;
        tick(1);
        abort_i = 1'b0;
        @(negedge clk);
        check("tmo_abort_clear", 32'({fault_o, state_o}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_trigger_ctrl.md
SYNC_TRIGGER_CTRL -- requirements
Module: sync_trigger_ctrl

Interface
REQ-001 SHALL have parameter N_OUT, default 4: number of delayed trigger channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32: width of delay and timeout counters in clk cycles.
REQ-003 SHALL have parameter PW_W, default 8: width of the detonator pulse-length field.
REQ-004 SHALL have ports: clk  in  1  system clock, 100 MHz nominal.
REQ-005 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: start_i  in  1  start condition (asynchronous; ≥1 clk wide).
REQ-007 SHALL have ports: fast_gate_i  in  1  fast gate window (asynchronous; level).
REQ-008 SHALL have ports: phase_i  in  1  phase reference (asynchronous; rising edge used).
REQ-009 SHALL have ports: wire_i  in  1  wire sensor (asynchronous; rising edge used).
REQ-010 SHALL have ports: abort_i  in  1  synchronous abort.
REQ-011 SHALL have ports: cfg_delay_i  in  N_OUT*CNT_W  per-channel delay after the wire edge, channel k in bits [k*CNT_W +: CNT_W].
REQ-012 SHALL have ports: cfg_pulse_len_i  in  PW_W  detonator pulse length in cycles.
REQ-013 SHALL have ports: cfg_timeout_i  in  CNT_W  wire-sensor timeout in cycles.
REQ-014 SHALL have ports: det_o  out  1  detonator fire pulse; trig_o  out  N_OUT  channel triggers; busy_o, done_o, fault_o  out  1 each  status; state_o  out  3  FSM state.

Function
REQ-015 SHALL pass start_i, fast_gate_i, phase_i and wire_i through 2-FF synchronisers; edge detection SHALL use the synchronised value, for a 3-cycle input-to-action latency.
REQ-016 SHALL implement states IDLE, WAIT_GATE, WAIT_PHASE, FIRE, WAIT_WIRE, TRIGGER, DONE, FAULT.
REQ-017 IDLE -> WAIT_GATE on the start rising edge; start edges in any other state SHALL be ignored.
REQ-018 WAIT_GATE -> WAIT_PHASE while the gate is high; WAIT_PHASE -> WAIT_GATE if the gate falls before a phase rising edge.
REQ-019 WAIT_PHASE -> FIRE on a phase rising edge with the gate high; a simultaneous gate fall and phase edge SHALL count as inside the gate.
REQ-020 det_o SHALL be high for exactly max(cfg_pulse_len_i,1) cycles starting the cycle after FIRE entry, then the FSM SHALL go to WAIT_WIRE.
REQ-021 cfg_* inputs SHALL be sampled into registers on the start edge and held until IDLE.
REQ-022 On a wire rising edge in WAIT_WIRE the FSM SHALL enter TRIGGER and clear a free-running cycle counter to 0.
REQ-023 In TRIGGER, trig_o[k] SHALL be a 1-cycle pulse when the counter equals the latched delay[k]; delay 0 fires the cycle of TRIGGER entry.
REQ-024 Equal delays SHALL fire their channels in the same cycle.
REQ-025 TRIGGER -> DONE in the cycle after the last channel fires; the counter SHALL saturate at all-ones, never wrap.
REQ-026 done_o SHALL pulse 1 cycle in DONE, then the FSM SHALL return to IDLE.
REQ-027 busy_o SHALL be high in every state except IDLE.
REQ-028 abort_i in any state SHALL force IDLE next cycle and clear det_o and trig_o; abort SHALL win over a simultaneous start.
REQ-029 FAULT SHALL hold fault_o high until abort_i or reset.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, all counters and synchronisers to 0, and all outputs to 0.
REQ-031 Reset mid-FIRE SHALL drop det_o immediately, with no pulse completion.

Configuration
REQ-032 Macro SYNC_WIRE_TIMEOUT_EN defined: WAIT_WIRE SHALL count cycles, and entry +cfg_timeout_i cycles without a wire edge SHALL go to FAULT (timeout 0 means disabled).
REQ-033 Macro SYNC_WIRE_TIMEOUT_EN undefined: WAIT_WIRE SHALL wait indefinitely, fault_o SHALL be tied to 0, and the timeout counter SHALL be absent.

Structure
REQ-034 Package sync_pkg SHALL hold the state enum (3-bit), the state encodings used on state_o, and default width constants.
REQ-035 Sub-module sync_edge_det (2-FF synchroniser plus rising-edge detector, 1 bit) SHALL be instantiated once per asynchronous input.

Verification
REQ-036 Start at t=25 ms, 100 ms gate period with 100 us open, 1.22 us phase, delays {0,10,100,1000}, pulse_len 10 -> det_o is 10 cycles in the first open gate, aligned to the phase edge +3 cycles; wire at det+5 ms gives trig_o at +3,+13,+103,+1003 cycles; done_o pulses once.
REQ-037 Gate closes with no phase edge -> FSM returns to WAIT_GATE and det_o stays 0 until the next window.
REQ-038 A second start pulse during WAIT_WIRE -> ignored; one done_o only.
REQ-039 abort_i asserted during det_o -> det_o 0 next cycle, state IDLE, no trig_o.
REQ-040 SYNC_WIRE_TIMEOUT_EN, timeout 1000, no wire -> fault_o high 1000 cycles after WAIT_WIRE entry; cleared by abort.
REQ-041 rst_n low mid-TRIGGER -> all outputs 0 immediately; after release, start works normally.
